// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter and scoreboard: round-robin sharing of the register bank write port
// between the ALU (A) and load unit (B), with busy tracking and hazard stall for issue.
module reg_wb_arbiter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ADD_WIDTH = 5,
    parameter int unsigned DEPTH     = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic [ADD_WIDTH-1:0] issue_rd,
    input  logic [ADD_WIDTH-1:0] issue_rs1,
    input  logic [ADD_WIDTH-1:0] issue_rs2,
    output logic                 issue_stall,
    input  logic                 a_valid,
    input  logic [ADD_WIDTH-1:0] a_reg,
    input  logic [WIDTH-1:0]     a_data,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [ADD_WIDTH-1:0] b_reg,
    input  logic [WIDTH-1:0]     b_data,
    output logic                 b_ready,
    output logic                 w_en,
    output logic [ADD_WIDTH-1:0] w_reg,
    output logic [WIDTH-1:0]     w_data,
    output logic [DEPTH-1:0]     busy,
    output logic                 err
);

    localparam int unsigned        NREG    = 1 << ADD_WIDTH;
    localparam logic [ADD_WIDTH:0] DEPTH_W = (ADD_WIDTH + 1)'(DEPTH);
    localparam logic               LAST_A  = 1'b0;
    localparam logic               LAST_B  = 1'b1;

    logic [DEPTH-1:0]     busy_q, busy_d;
    logic                 last_q, last_d;
    logic                 w_en_q, w_en_d;
    logic [ADD_WIDTH-1:0] w_reg_q, w_reg_d;
    logic [WIDTH-1:0]     w_data_q, w_data_d;
    logic                 err_q, err_d;

    logic [NREG-1:0]      busy_ext;
    logic                 issue_fire;
    logic [ADD_WIDTH-1:0] sel_reg;
    logic [WIDTH-1:0]     sel_data;
    logic                 sel_in_range;

    // Zero-extended view so out-of-range addresses read as not busy
    assign busy_ext = NREG'(busy_q);

    assign issue_stall = rst | (issue_valid & (busy_ext[issue_rs1] | busy_ext[issue_rs2]
                                               | busy_ext[issue_rd]));
    assign issue_fire  = issue_valid & ~issue_stall;

    assign a_ready = ~rst & a_valid & (~b_valid | (last_q == LAST_B));
    assign b_ready = ~rst & b_valid & (~a_valid | (last_q == LAST_A));

    assign sel_reg      = b_ready ? b_reg  : a_reg;
    assign sel_data     = b_ready ? b_data : a_data;
    assign sel_in_range = {1'b0, sel_reg} < DEPTH_W;

    // Next-state for write stage, grant pointer and scoreboard
    always_comb begin
        busy_d   = busy_q;
        last_d   = last_q;
        w_en_d   = 1'b0;
        w_reg_d  = w_reg_q;
        w_data_d = w_data_q;
        err_d    = 1'b0;

        if (a_ready || b_ready) begin
            last_d   = b_ready ? LAST_B : LAST_A;
            w_reg_d  = sel_reg;
            w_data_d = sel_data;
            w_en_d   = sel_in_range && (sel_reg != '0);
            err_d    = ~sel_in_range;
        end

        // Clear on the bank write edge; issue never targets a busy register, so no conflict
        for (int unsigned r = 1; r < DEPTH; r++) begin
            if (w_en_q && (w_reg_q == ADD_WIDTH'(r))) begin
                busy_d[r] = 1'b0;
            end
            if (issue_fire && (issue_rd == ADD_WIDTH'(r))) begin
                busy_d[r] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= '0;
            last_q   <= LAST_B;
            w_en_q   <= 1'b0;
            w_reg_q  <= '0;
            w_data_q <= '0;
            err_q    <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            last_q   <= last_d;
            w_en_q   <= w_en_d;
            w_reg_q  <= w_reg_d;
            w_data_q <= w_data_d;
            err_q    <= err_d;
        end
    end

    assign w_en   = w_en_q;
    assign w_reg  = w_reg_q;
    assign w_data = w_data_q;
    assign busy   = busy_q;
    assign err    = err_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed scenarios followed by random traffic, all checked
// against a rule-level model of scoreboard, round-robin grant and write stage.
module tb_reg_wb_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_valid;
    logic [AW-1:0]    issue_rd, issue_rs1, issue_rs2;
    logic             issue_stall;
    logic             a_valid, b_valid, a_ready, b_ready;
    logic [AW-1:0]    a_reg, b_reg;
    logic [WIDTH-1:0] a_data, b_data;
    logic             w_en;
    logic [AW-1:0]    w_reg;
    logic [WIDTH-1:0] w_data;
    logic [DEPTH-1:0] busy;
    logic             err;

    reg_wb_arbiter #(.WIDTH(WIDTH), .ADD_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
        .issue_rs2(issue_rs2), .issue_stall(issue_stall),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .w_en(w_en), .w_reg(w_reg), .w_data(w_data), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Register bank stand-in: no reset, writes whenever w_en is seen
    logic [WIDTH-1:0] bank [32];
    always @(posedge clk) if (w_en) bank[w_reg] <= w_data;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit               m_busy [32];
    bit               claimed [32];
    int               m_last;   // 1 = A granted most recently, 2 = B
    int               m_grant;  // grant taken at the last edge: 0 none, 1 A, 2 B
    bit               m_wen, m_err;
    logic [AW-1:0]    m_wreg;
    logic [WIDTH-1:0] m_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit mb(input logic [AW-1:0] r);
        return (r < AW'(DEPTH)) ? m_busy[r] : 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin m_busy[i] = 0; claimed[i] = 0; end
        m_last = 2; m_grant = 0; m_wen = 0; m_err = 0; m_wreg = '0; m_wdata = '0;
    endtask

    // One clock: check combinational outputs mid-cycle, then registered outputs after the edge
    task automatic cycle();
        bit exp_stall, fire;
        int g;
        logic [AW-1:0]    greg;
        logic [WIDTH-1:0] gdata;
        logic [DEPTH-1:0] eb;
        @(negedge clk);
        exp_stall = rst || (issue_valid && (mb(issue_rs1) || mb(issue_rs2) || mb(issue_rd)));
        fire = issue_valid && !exp_stall;
        g = 0;
        if (!rst) begin
            if (a_valid && b_valid) g = (m_last == 1) ? 2 : 1;
            else if (a_valid)       g = 1;
            else if (b_valid)       g = 2;
        end
        greg  = (g == 2) ? b_reg  : a_reg;
        gdata = (g == 2) ? b_data : a_data;
        chk("issue_stall", 32'(issue_stall), 32'(exp_stall));
        chk("a_ready", 32'(a_ready), 32'(g == 1));
        chk("b_ready", 32'(b_ready), 32'(g == 2));
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            if (m_wen) begin m_busy[m_wreg] = 0; claimed[m_wreg] = 0; end
            if (fire && issue_rd != 0 && issue_rd < AW'(DEPTH)) m_busy[issue_rd] = 1;
            m_grant = g;
            if (g != 0) begin
                m_last  = g;
                m_wreg  = greg;
                m_wdata = gdata;
                m_wen   = (greg != 0) && (greg < AW'(DEPTH));
                m_err   = (greg >= AW'(DEPTH));
            end else begin
                m_wen = 0;
                m_err = 0;
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) eb[i] = m_busy[i];
        chk("w_en", 32'(w_en), 32'(m_wen));
        chk("w_reg", 32'(w_reg), 32'(m_wreg));
        chk("w_data", w_data, m_wdata);
        chk("busy", 32'(busy), 32'(eb));
        chk("err", 32'(err), 32'(m_err));
    endtask

    // Random writeback target: usually an unclaimed busy register, sometimes r0 or out of range
    task automatic pick(output logic v, output logic [AW-1:0] r);
        int k, s, c;
        k = int'($urandom_range(0, 9));
        v = 1'b1;
        r = '0;
        if (k == 1) begin
            r = AW'($urandom_range(15, 31));
        end else if (k != 0) begin
            v = 1'b0;
            s = int'($urandom_range(1, 14));
            for (int i = 0; i < 14; i++) begin
                c = 1 + (s - 1 + i) % 14;
                if (!v && m_busy[c] && !claimed[c]) begin
                    v = 1'b1;
                    r = AW'(c);
                    claimed[c] = 1;
                end
            end
        end
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
        a_valid = 0; a_reg = '0; a_data = '0;
        b_valid = 0; b_reg = '0; b_data = '0;
    endtask

    initial begin
        logic av, bv;
        logic [AW-1:0] ar, br;
        model_reset();
        idle_inputs();
        rst = 1;
        cycle();
        cycle();
        rst = 0;

        // Clean issue sets busy[3]
        issue_valid = 1; issue_rd = 5'd3; issue_rs1 = 5'd1; issue_rs2 = 5'd2;
        cycle();
        chk("plan_busy3", 32'(busy), 32'h0008);

        // RAW on r3 stalls until A's writeback lands
        issue_rd = 5'd7; issue_rs1 = 5'd3; issue_rs2 = 5'd0;
        cycle();
        chk("plan_raw_stall", 32'(issue_stall), 32'd1);
        a_valid = 1; a_reg = 5'd3; a_data = 32'hDEADBEEF;
        cycle();
        a_valid = 0;
        chk("plan_wen3", 32'(w_en), 32'd1);
        chk("plan_wreg3", 32'(w_reg), 32'd3);
        cycle();
        chk("plan_busy3_clr", 32'(busy[3]), 32'd0);
        chk("plan_bank3", bank[3], 32'hDEADBEEF);
        chk("plan_stall_drop", 32'(issue_stall), 32'd0);
        cycle();
        issue_valid = 0;

        // Round-robin from reset: A, B, A, B
        rst = 1;
        cycle();
        rst = 0;
        a_valid = 1; a_reg = 5'd4; a_data = 32'h4444_0004;
        b_valid = 1; b_reg = 5'd5; b_data = 32'h5555_0005;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("plan_rr_wreg", 32'(w_reg), (i % 2 == 0) ? 32'd4 : 32'd5);
        end
        a_valid = 0; b_valid = 0;

        // r0 is dropped quietly; r15 is dropped with a one-cycle err
        b_valid = 1; b_reg = 5'd0; b_data = 32'h1234_5678;
        cycle();
        b_valid = 0;
        chk("plan_r0_wen", 32'(w_en), 32'd0);
        chk("plan_r0_err", 32'(err), 32'd0);
        a_valid = 1; a_reg = 5'd15; a_data = 32'hBAD0_000F;
        cycle();
        a_valid = 0;
        chk("plan_oor_wen", 32'(w_en), 32'd0);
        chk("plan_oor_err", 32'(err), 32'd1);
        cycle();
        chk("plan_oor_err_pulse", 32'(err), 32'd0);

        // Reset lands on the edge where r6 is being written
        issue_valid = 1; issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd5;
        cycle();
        issue_rd = 5'd6;
        cycle();
        issue_valid = 0;
        chk("plan_busy56", 32'(busy), 32'h0060);
        a_valid = 1; a_reg = 5'd6; a_data = 32'h600D_0006;
        cycle();
        a_valid = 0;
        chk("plan_wen6", 32'(w_en), 32'd1);
        rst = 1;
        cycle();
        chk("plan_bank6", bank[6], 32'h600D_0006);
        chk("plan_rst_busy", 32'(busy), 32'd0);
        chk("plan_rst_wen", 32'(w_en), 32'd0);
        rst = 0;

        // Random traffic under the valid/hold protocol
        for (int i = 0; i < 32; i++) claimed[i] = 0;
        for (int n = 0; n < 400; n++) begin
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd  = AW'($urandom_range(0, 17));
            issue_rs1 = AW'($urandom_range(0, 17));
            issue_rs2 = AW'($urandom_range(0, 17));
            if (!a_valid || m_grant == 1) begin
                a_valid = 0;
                if ($urandom_range(0, 3) != 0) begin
                    pick(av, ar);
                    a_valid = av; a_reg = ar; a_data = $urandom;
                end
            end
            if (!b_valid || m_grant == 2) begin
                b_valid = 0;
                if ($urandom_range(0, 3) != 0) begin
                    pick(bv, br);
                    b_valid = bv; b_reg = br; b_data = $urandom;
                end
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
